// File: rtl/cvae_state_wb_if.sv
// State write-back bus: decoder word stream into the controller plus the
// state-SRAM write port driven by the controller.
interface cvae_state_wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  st_valid;
    logic                  st_ready;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  st_term;
    logic                  sram_state_wea;
    logic [ADDR_WIDTH-1:0] sram_state_addr;
    logic [DATA_WIDTH-1:0] sram_state_wdata;

    // Datapath / observer side
    modport master (
        output st_valid, st_data, st_term,
        input  st_ready, sram_state_wea, sram_state_addr, sram_state_wdata
    );

    // Controller side
    modport slave (
        input  st_valid, st_data, st_term,
        output st_ready, sram_state_wea, sram_state_addr, sram_state_wdata
    );
endinterface

// File: rtl/cvae_state_wb_ctrl.sv
// State-SRAM write-back controller: assigns sequential addresses to streamed
// state vectors, counts committed decode steps and ends the session.
module cvae_state_wb_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int STATE_WORDS = 13,
    parameter int MAX_SEQ     = 59,
    parameter int BASE_ADDR   = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    cvae_state_wb_if.slave     st,
    output logic [5:0]         seq_lens,
    output logic               busy,
    output logic               done
);
    localparam int WORD_W = (STATE_WORDS > 1) ? $clog2(STATE_WORDS) : 1;
    localparam int STEP_W = 6;

    localparam logic [WORD_W-1:0]     LAST_WORD = WORD_W'(STATE_WORDS - 1);
    localparam logic [STEP_W-1:0]     MAX_STEP  = STEP_W'(MAX_SEQ);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_LAST,
        S_DONE
    } state_t;

    state_t                  state_reg;
    logic [WORD_W-1:0]       word_cnt_reg;
    logic [STEP_W-1:0]       step_cnt_reg;
    logic [ADDR_WIDTH-1:0]   addr_ptr_reg;
    logic                    ready_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic [5:0]              seq_lens_reg;
    logic                    wea_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;

    logic                    accept;
    logic                    vector_end;
    logic [STEP_W-1:0]       step_next;

    assign accept     = st.st_valid & ready_reg;
    assign vector_end = (word_cnt_reg == LAST_WORD);
    assign step_next  = step_cnt_reg + STEP_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            word_cnt_reg <= '0;
            step_cnt_reg <= '0;
            addr_ptr_reg <= BASE;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            seq_lens_reg <= '0;
            wea_reg      <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
        end else begin
            wea_reg <= 1'b0;
            // start wins over any concurrent handshake; a write already on
            // the SRAM port (LAST) has completed by this edge.
            if (start) begin
                state_reg    <= S_RUN;
                word_cnt_reg <= '0;
                step_cnt_reg <= '0;
                addr_ptr_reg <= BASE;
                ready_reg    <= 1'b1;
                busy_reg     <= 1'b1;
                done_reg     <= 1'b0;
                seq_lens_reg <= '0;
            end else begin
                unique case (state_reg)
                    S_RUN: begin
                        if (accept) begin
                            wea_reg      <= 1'b1;
                            addr_reg     <= addr_ptr_reg;
                            wdata_reg    <= st.st_data;
                            addr_ptr_reg <= addr_ptr_reg + ADDR_WIDTH'(1);
                            if (vector_end) begin
                                word_cnt_reg <= '0;
                                step_cnt_reg <= step_next;
                                seq_lens_reg <= (step_next > MAX_STEP) ? MAX_STEP : step_next;
                                // st_term only counts on the closing word of a vector
                                if (st.st_term || (step_next == MAX_STEP)) begin
                                    state_reg <= S_LAST;
                                    ready_reg <= 1'b0;
                                end
                            end else begin
                                word_cnt_reg <= word_cnt_reg + WORD_W'(1);
                            end
                        end
                    end
                    S_LAST: begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign st.st_ready         = ready_reg;
    assign st.sram_state_wea   = wea_reg;
    assign st.sram_state_addr  = addr_reg;
    assign st.sram_state_wdata = wdata_reg;
    assign seq_lens            = seq_lens_reg;
    assign busy                = busy_reg;
    assign done                = done_reg;
endmodule

// File: tb/tb_cvae_state_wb_ctrl.sv
// Randomized self-checking bench for cvae_state_wb_ctrl against a
// word-count based session model and a shadow copy of the state SRAM.
module tb_cvae_state_wb_ctrl;
    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int SW   = 13;
    localparam int MAXS = 59;
    localparam int BASE = 13;
    localparam int DEPTH = 780;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] seq_lens;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    cvae_state_wb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    cvae_state_wb_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .STATE_WORDS(SW),
        .MAX_SEQ    (MAXS),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .st      (bus.slave),
        .seq_lens(seq_lens),
        .busy    (busy),
        .done    (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // session model: words accepted so far decide address, step count and end
    bit          m_active;
    bit          m_finishing;
    bit          m_done;
    int          m_words;
    int          m_seq;
    bit          e_wea;
    int          e_addr;
    logic [31:0] e_wdata;

    logic [31:0] mem [DEPTH];
    int          wr_count;
    int          last_addr;
    logic [31:0] last_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit s, input bit v, input logic [31:0] d, input bit t);
        e_wea = 1'b0;
        if (r) begin
            m_active = 0; m_finishing = 0; m_done = 0; m_words = 0; m_seq = 0;
        end else if (s) begin
            m_active = 1; m_finishing = 0; m_done = 0; m_words = 0; m_seq = 0;
        end else if (m_finishing) begin
            m_finishing = 0;
            m_done      = 1;
        end else if (m_active && v) begin
            e_wea   = 1'b1;
            e_addr  = BASE + m_words;
            e_wdata = d;
            m_words++;
            if (m_words % SW == 0) begin
                m_seq = m_words / SW;
                if (t || m_seq == MAXS) begin
                    m_active    = 0;
                    m_finishing = 1;
                end
            end
        end
    endtask

    task automatic sample_outputs();
        check("wea",      32'(bus.sram_state_wea), 32'(e_wea));
        check("st_ready", 32'(bus.st_ready),       32'(m_active));
        check("busy",     32'(busy),               32'(m_active | m_finishing));
        check("done",     32'(done),               32'(m_done));
        check("seq_lens", 32'(seq_lens),           32'(m_seq));
        if (e_wea) begin
            check("addr",  32'(bus.sram_state_addr), 32'(e_addr));
            check("wdata", bus.sram_state_wdata,      e_wdata);
        end
        if (bus.sram_state_wea) begin
            wr_count++;
            last_addr = int'(bus.sram_state_addr);
            last_data = bus.sram_state_wdata;
            if (last_addr < DEPTH) mem[last_addr] = last_data;
            $display("[TB] wr addr=%0d data=0x%08h seq_lens=%0d", last_addr, last_data, seq_lens);
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit v, input logic [31:0] d, input bit t);
        rst          = r;
        start        = s;
        bus.st_valid = v;
        bus.st_data  = d;
        bus.st_term  = t;
        @(posedge clk);
        model_edge(r, s, v, d, t);
        @(negedge clk);
        sample_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;
        wr_count = 0; last_addr = -1; last_data = '0;
        e_addr = 0; e_wdata = '0;
        m_active = 0; m_finishing = 0; m_done = 0; m_words = 0; m_seq = 0; e_wea = 0;

        // reset state
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 32'h0, 0);
        check("rst_addr",  32'(bus.sram_state_addr), 32'h0);
        check("rst_wdata", bus.sram_state_wdata,      32'h0);
        idle(2);

        // single terminal step
        cyc(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < SW; i++) cyc(0, 0, 1, 32'hA000_0000 + 32'(i), i == SW - 1);
        idle(3);
        for (int i = 0; i < SW; i++) check("t1_mem", mem[BASE + i], 32'hA000_0000 + 32'(i));
        check("t1_seq",  32'(seq_lens), 32'd1);
        check("t1_done", 32'(done),     32'd1);

        // gapped stream, st_term noise on non-final words, terminal on vector 3
        wr_count = 0;
        cyc(0, 1, 0, 32'h0, 0);
        for (int c = 0; c < 400 && m_active; c++) begin
            bit t;
            if (m_words % SW == SW - 1) t = (m_words / SW == 2);
            else                        t = 1'($urandom_range(0, 1));
            cyc(0, 0, c[0] == 1'b0, $urandom, t);
        end
        idle(2);
        check("t2_writes",    32'(wr_count),  32'd39);
        check("t2_last_addr", 32'(last_addr), 32'd51);
        check("t2_seq",       32'(seq_lens),  32'd3);

        // MAX_SEQ limit with extra words offered afterwards
        wr_count = 0;
        cyc(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < MAXS * SW + 8; i++) cyc(0, 0, 1, $urandom, 0);
        check("t3_writes",    32'(wr_count),  32'(MAXS * SW));
        check("t3_last_addr", 32'(last_addr), 32'd779);
        check("t3_mem_779",   mem[779],       last_data);
        check("t3_seq",       32'(seq_lens),  32'd59);
        check("t3_done",      32'(done),      32'd1);

        // restart mid-vector (start coincides with a valid word)
        cyc(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, $urandom, 0);
        cyc(0, 1, 1, 32'hDEAD_BEEF, 1);
        check("t4_seq0", 32'(seq_lens), 32'd0);
        cyc(0, 0, 1, 32'h5555_0000, 0);
        check("t4_first_addr", 32'(last_addr), 32'd13);
        for (int i = 1; i < SW; i++) cyc(0, 0, 1, $urandom, i == SW - 1);
        idle(2);
        check("t4_seq", 32'(seq_lens), 32'd1);

        // reset during step 5, then words without start
        cyc(0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 5 * SW + 4; i++) cyc(0, 0, 1, $urandom, 0);
        cyc(1, 0, 1, $urandom, 0);
        wr_count = 0;
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, $urandom, 1);
        check("t5_no_wr", 32'(wr_count), 32'd0);

        // random traffic with occasional start/rst
        for (int c = 0; c < 1500; c++) begin
            bit r, s;
            r = ($urandom_range(0, 499) == 0);
            s = ($urandom_range(0, 199) == 0) ||
                (!m_active && !m_finishing && $urandom_range(0, 9) == 0);
            cyc(r, s, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 7) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
